// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl -- IEEE 1149.1 TAP controller clocked by the system clock.
//
// TCK/TMS/TDI are oversampled through synchronizers. The TAP FSM advances on
// a detected TCK rise. TDO and tdo_en change on a detected TCK fall. The
// 5-bit EJTAG instruction register is decoded to a 4-bit DR select for the
// external DR mux. Capture and shift clocks for that mux appear as one-clk
// strobes (clk_dr). Update appears as a one-clk strobe (update_dr).
//
// Optional build macro:
//   JTAG_TRST_EN  adds the trst_n pin (active-low, asynchronous, synchronized).
//                 While it is low, the TAP is held in Test-Logic-Reset.
//
// Ports:
//   clk, rst           system clock; synchronous active-high reset
//   tck, tms, tdi      JTAG pins (asynchronous to clk)
//   trst_n             optional JTAG reset pin (JTAG_TRST_EN only)
//   tdo, tdo_en        registered serial out and its output enable
//   s_data_in          serial out bit of the selected DR
//   sel                DR select decoded from the instruction register
//   shift_dr           level, high in Shift-DR
//   clk_dr             strobe per TCK rise in Capture-DR / Shift-DR
//   update_dr          strobe on entry to Update-DR
//   tlr                high in Test-Logic-Reset
module jtag_tap_ctrl #(
  parameter int IR_WIDTH    = 5,
  parameter logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(5'b00001),
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tck,
  input  logic       tms,
  input  logic       tdi,
`ifdef JTAG_TRST_EN
  input  logic       trst_n,
`endif
  output logic       tdo,
  output logic       tdo_en,
  input  logic       s_data_in,
  output logic [3:0] sel,
  output logic       shift_dr,
  output logic       clk_dr,
  output logic       update_dr,
  output logic       tlr
);

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
  } tap_state_e;

  localparam logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(5'h01);

  // ---------------------------------------------------------------------------
  // Pin synchronizers
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] tck_sync, tms_sync, tdi_sync;
  logic tck_d;
  logic tck_s, tms_s, tdi_s;
  logic tck_rise, tck_fall;
  logic trst_act;

  always_ff @(posedge clk) begin
    if (rst) begin
      tck_sync <= '0;
      tms_sync <= '0;
      tdi_sync <= '0;
      tck_d    <= 1'b0;
    end else begin
      tck_sync <= {tck_sync[SYNC_STAGES-2:0], tck};
      tms_sync <= {tms_sync[SYNC_STAGES-2:0], tms};
      tdi_sync <= {tdi_sync[SYNC_STAGES-2:0], tdi};
      tck_d    <= tck_sync[SYNC_STAGES-1];
    end
  end

  assign tck_s    = tck_sync[SYNC_STAGES-1];
  assign tms_s    = tms_sync[SYNC_STAGES-1];
  assign tdi_s    = tdi_sync[SYNC_STAGES-1];
  assign tck_rise = tck_s & ~tck_d;
  assign tck_fall = ~tck_s & tck_d;

`ifdef JTAG_TRST_EN
  logic [SYNC_STAGES-1:0] trst_sync;

  always_ff @(posedge clk) begin
    if (rst) trst_sync <= '0;
    else     trst_sync <= {trst_sync[SYNC_STAGES-2:0], trst_n};
  end

  // The chain clears to 0. The TAP therefore stays in TLR for a few clk
  // after rst until the deasserted pin has propagated through the chain.
  assign trst_act = ~trst_sync[SYNC_STAGES-1];
`else
  assign trst_act = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // TAP FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  tap_state_e state, state_next;

  always_ff @(posedge clk) begin
    if (rst || trst_act) state <= TLR;
    else                 state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (tck_rise) begin
      case (state)
        TLR:     state_next = tms_s ? TLR    : RTI;
        RTI:     state_next = tms_s ? SEL_DR : RTI;
        SEL_DR:  state_next = tms_s ? SEL_IR : CAP_DR;
        CAP_DR:  state_next = tms_s ? EX1_DR : SH_DR;
        SH_DR:   state_next = tms_s ? EX1_DR : SH_DR;
        EX1_DR:  state_next = tms_s ? UPD_DR : PA_DR;
        PA_DR:   state_next = tms_s ? EX2_DR : PA_DR;
        EX2_DR:  state_next = tms_s ? UPD_DR : SH_DR;
        UPD_DR:  state_next = tms_s ? SEL_DR : RTI;
        SEL_IR:  state_next = tms_s ? TLR    : CAP_IR;
        CAP_IR:  state_next = tms_s ? EX1_IR : SH_IR;
        SH_IR:   state_next = tms_s ? EX1_IR : SH_IR;
        EX1_IR:  state_next = tms_s ? UPD_IR : PA_IR;
        PA_IR:   state_next = tms_s ? EX2_IR : PA_IR;
        EX2_IR:  state_next = tms_s ? UPD_IR : SH_IR;
        UPD_IR:  state_next = tms_s ? SEL_DR : RTI;
        default: state_next = TLR;
      endcase
    end
  end

  // clk_dr follows the same tck_rise that moves the FSM out of CAP_DR/SH_DR.
  // rst (and trst) win over a coincident edge.
  always_comb begin
    tlr      = (state == TLR);
    shift_dr = (state == SH_DR);
    clk_dr   = tck_rise && !rst && !trst_act &&
               ((state == CAP_DR) || (state == SH_DR));
  end

  // Update-DR is never re-entered from itself. A registered copy of the
  // entry condition therefore gives exactly one clk in the first UPD_DR cycle.
  always_ff @(posedge clk) begin
    if (rst || trst_act) update_dr <= 1'b0;
    else                 update_dr <= tck_rise && (state_next == UPD_DR);
  end

  // ---------------------------------------------------------------------------
  // Instruction register
  // ---------------------------------------------------------------------------
  logic [IR_WIDTH-1:0] ir_sh, ir;

  always_ff @(posedge clk) begin
    if (rst || trst_act) begin
      ir_sh <= IR_CAPTURE;
    end else if (tck_rise) begin
      if (state == CAP_IR)     ir_sh <= IR_CAPTURE;
      else if (state == SH_IR) ir_sh <= {tdi_s, ir_sh[IR_WIDTH-1:1]};
    end
  end

  // ir only moves on entry to UPD_IR or while in TLR. sel is therefore
  // stable through every DR state.
  always_ff @(posedge clk) begin
    if (rst || trst_act)                      ir <= OP_IDCODE;
    else if (state == TLR)                    ir <= OP_IDCODE;
    else if (tck_rise && state_next == UPD_IR) ir <= ir_sh;
  end

  always_comb begin
    case (ir)
      IR_WIDTH'(5'h01): sel = 4'd0;
      IR_WIDTH'(5'h03): sel = 4'd1;
      IR_WIDTH'(5'h08): sel = 4'd2;
      IR_WIDTH'(5'h09): sel = 4'd3;
      IR_WIDTH'(5'h0A): sel = 4'd4;
      IR_WIDTH'(5'h0C): sel = 4'd5;
      IR_WIDTH'(5'h02): sel = 4'd6;
      default:          sel = 4'd7;  // 0x1F and all unknown opcodes: BYPASS
    endcase
  end

  // ---------------------------------------------------------------------------
  // TDO: changes only on a TCK fall, so the value is stable for the next rise
  // seen by the external host.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      tdo <= 1'b0;
    end else if (tck_fall) begin
      if (state == SH_IR)      tdo <= ir_sh[0];
      else if (state == SH_DR) tdo <= s_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || trst_act) tdo_en <= 1'b0;
    else if (tck_fall)   tdo_en <= (state == SH_IR) || (state == SH_DR);
  end

endmodule
